// File: rtl/svm_submit_arbiter.sv
// rtl/svm_submit_arbiter.sv - round-robin submit arbiter sharing one SVM scheduler pipeline
//
// Purpose:
//   Grants one of NUM_REQ transaction sources in round-robin order and latches
//   its program ID and read/write dependency sets. Issues the transaction to the
//   scheduler as a one-cycle pulse and waits for accept, conflict or timeout.
//   Conflicts are retried after a fixed backoff, up to MAX_RETRY re-issues.
//   A per-requester completion pulse carries the final status.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/req_programID/
//   req_read_deps/req_write_deps  per-requester transaction (held until req_ready)
//   req_ready                     one-cycle capture pulse for the granted requester
//   resp_done/resp_status/
//   resp_conflict_id              completion pulse, 00 accepted / 01 conflict / 10 timeout
//   owner_programID/read_dependencies/
//   write_dependencies/transaction_valid   issue interface to the scheduler
//   transaction_accepted/has_conflict/
//   conflicting_id                scheduler response
//   busy                          arbiter not idle
//   accept_count/conflict_count   saturating response counters
module svm_submit_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int DEPS_PER_TRANSACTION = 1024,
  parameter int MAX_RETRY            = 3,
  parameter int BACKOFF_CYCLES       = 8,
  parameter int TIMEOUT_CYCLES       = 256,
  localparam int DEP_W               = DEPS_PER_TRANSACTION * 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*64-1:0]    req_programID,
  input  logic [NUM_REQ*DEP_W-1:0] req_read_deps,
  input  logic [NUM_REQ*DEP_W-1:0] req_write_deps,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_done,
  output logic [1:0]               resp_status,
  output logic [63:0]              resp_conflict_id,
  output logic [63:0]              owner_programID,
  output logic [DEP_W-1:0]         read_dependencies,
  output logic [DEP_W-1:0]         write_dependencies,
  output logic                     transaction_valid,
  input  logic                     transaction_accepted,
  input  logic                     has_conflict,
  input  logic [63:0]              conflicting_id,
  output logic                     busy,
  output logic [31:0]              accept_count,
  output logic [31:0]              conflict_count
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BO_W    = $clog2(BACKOFF_CYCLES + 1);

  localparam logic [PTR_W-1:0]   LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF_CYCLES - 1);

  localparam logic [1:0] ST_ACCEPTED = 2'b00;
  localparam logic [1:0] ST_CONFLICT = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   pick_next;
  logic [PTR_W-1:0]   cand;
  logic               any_req;
  logic               first_issue;
  logic [RETRY_W-1:0] retry_cnt;
  logic [TMO_W-1:0]   timeout_cnt;
  logic [BO_W-1:0]    backoff_cnt;
  logic [63:0]        last_conflict;

  // Round-robin search: first requester at or above ptr, wrapping past NUM_REQ-1.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr) + i >= NUM_REQ) begin
        cand = PTR_W'(int'(ptr) + i - NUM_REQ);
      end else begin
        cand = PTR_W'(int'(ptr) + i);
      end
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign pick_next = (pick == LAST_REQ) ? '0 : pick + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    transaction_valid = 1'b0;
    req_ready         = '0;
    resp_done         = '0;
    busy              = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        transaction_valid = 1'b1;
        // Retries reuse the captured data, so the requester only sees ready once.
        if (first_issue) begin
          req_ready[grant] = 1'b1;
        end
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (transaction_accepted) begin
          state_next = S_RESP;
        end else if (has_conflict) begin
          state_next = (retry_cnt < RETRY_MAX) ? S_BACKOFF : S_RESP;
        end else if (timeout_cnt == TMO_LAST) begin
          state_next = S_RESP;
        end
      end
      S_BACKOFF: begin
        if (backoff_cnt == BO_LAST) begin
          state_next = S_ISSUE;
        end
      end
      S_RESP: begin
        resp_done[grant] = 1'b1;
        state_next       = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr                <= '0;
      grant              <= '0;
      first_issue        <= 1'b0;
      retry_cnt          <= '0;
      timeout_cnt        <= '0;
      backoff_cnt        <= '0;
      last_conflict      <= '0;
      resp_status        <= 2'b00;
      resp_conflict_id   <= '0;
      owner_programID    <= '0;
      read_dependencies  <= '0;
      write_dependencies <= '0;
      accept_count       <= '0;
      conflict_count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant              <= pick;
            ptr                <= pick_next;
            owner_programID    <= req_programID[pick*64 +: 64];
            read_dependencies  <= req_read_deps[pick*DEP_W +: DEP_W];
            write_dependencies <= req_write_deps[pick*DEP_W +: DEP_W];
            retry_cnt          <= '0;
            first_issue        <= 1'b1;
            last_conflict      <= '0;
          end
        end
        S_ISSUE: begin
          timeout_cnt <= '0;
          first_issue <= 1'b0;
        end
        S_WAIT: begin
          // Accept outranks a simultaneous conflict.
          if (transaction_accepted) begin
            resp_status      <= ST_ACCEPTED;
            resp_conflict_id <= last_conflict;
            if (accept_count != 32'hFFFF_FFFF) begin
              accept_count <= accept_count + 32'd1;
            end
          end else if (has_conflict) begin
            last_conflict <= conflicting_id;
            if (conflict_count != 32'hFFFF_FFFF) begin
              conflict_count <= conflict_count + 32'd1;
            end
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt   <= retry_cnt + RETRY_W'(1);
              backoff_cnt <= '0;
            end else begin
              resp_status      <= ST_CONFLICT;
              resp_conflict_id <= conflicting_id;
            end
          end else begin
            timeout_cnt <= timeout_cnt + TMO_W'(1);
            if (timeout_cnt == TMO_LAST) begin
              resp_status      <= ST_TIMEOUT;
              resp_conflict_id <= last_conflict;
            end
          end
        end
        S_BACKOFF: begin
          backoff_cnt <= backoff_cnt + BO_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svm_submit_arbiter.sv
// tb/tb_svm_submit_arbiter.sv - self-checking bench for svm_submit_arbiter
module tb_svm_submit_arbiter;

  localparam int NR   = 4;
  localparam int DEPS = 16;
  localparam int DW   = DEPS * 64;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*64-1:0]  req_programID;
  logic [NR*DW-1:0]  req_read_deps;
  logic [NR*DW-1:0]  req_write_deps;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     resp_done;
  logic [1:0]        resp_status;
  logic [63:0]       resp_conflict_id;
  logic [63:0]       owner_programID;
  logic [DW-1:0]     read_dependencies;
  logic [DW-1:0]     write_dependencies;
  logic              transaction_valid;
  logic              transaction_accepted;
  logic              has_conflict;
  logic [63:0]       conflicting_id;
  logic              busy;
  logic [31:0]       accept_count;
  logic [31:0]       conflict_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_accept   = 0;
  int exp_conflict = 0;

  int          grant_q[$];
  int          exp_idx_q[$];
  logic [1:0]  exp_st_q[$];
  logic [63:0] exp_cid_q[$];

  int          mon_g;
  int          mon_i;
  logic [1:0]  mon_s;
  logic [63:0] mon_c;

  svm_submit_arbiter #(
    .NUM_REQ(NR),
    .DEPS_PER_TRANSACTION(DEPS),
    .MAX_RETRY(3),
    .BACKOFF_CYCLES(8),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_programID(req_programID),
    .req_read_deps(req_read_deps),
    .req_write_deps(req_write_deps),
    .req_ready(req_ready),
    .resp_done(resp_done),
    .resp_status(resp_status),
    .resp_conflict_id(resp_conflict_id),
    .owner_programID(owner_programID),
    .read_dependencies(read_dependencies),
    .write_dependencies(write_dependencies),
    .transaction_valid(transaction_valid),
    .transaction_accepted(transaction_accepted),
    .has_conflict(has_conflict),
    .conflicting_id(conflicting_id),
    .busy(busy),
    .accept_count(accept_count),
    .conflict_count(conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every req_ready and resp_done pulse must match the front of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready !== '0) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL req_ready_unexpected: got %b, expected no pulse", req_ready);
        end else begin
          mon_g = grant_q.pop_front();
          if (req_ready !== (4'b0001 << mon_g)) begin
            errors++;
            $display("FAIL req_ready_grant: got %b, expected %b", req_ready, 4'b0001 << mon_g);
          end
        end
      end
      if (resp_done !== '0) begin
        checks++;
        if (exp_idx_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got done=%b status=%b", resp_done, resp_status);
        end else begin
          mon_i = exp_idx_q.pop_front();
          mon_s = exp_st_q.pop_front();
          mon_c = exp_cid_q.pop_front();
          if (resp_done !== (4'b0001 << mon_i) || resp_status !== mon_s || resp_conflict_id !== mon_c) begin
            errors++;
            $display("FAIL resp_content: got done=%b status=%b cid=%0d, expected done=%b status=%b cid=%0d",
                     resp_done, resp_status, resp_conflict_id, 4'b0001 << mon_i, mon_s, mon_c);
          end
        end
      end
    end
  end

  task automatic expect_resp(input int idx, input logic [1:0] st, input logic [63:0] cid);
    exp_idx_q.push_back(idx);
    exp_st_q.push_back(st);
    exp_cid_q.push_back(cid);
  endtask

  task automatic wait_tv(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (transaction_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (resp_done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0;
    req_programID = '0;
    req_read_deps = '0;
    req_write_deps = '0;
    transaction_accepted = 1'b0;
    has_conflict = 1'b0;
    conflicting_id = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_done, resp_status, resp_conflict_id, owner_programID, transaction_valid,
         busy, accept_count, conflict_count} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b st=%b cid=%0d owner=%0d tv=%b busy=%b acc=%0d conf=%0d, expected all 0",
               req_ready, resp_done, resp_status, resp_conflict_id, owner_programID, transaction_valid,
               busy, accept_count, conflict_count);
    end
    checks++;
    if (read_dependencies !== '0 || write_dependencies !== '0) begin
      errors++;
      $display("FAIL reset_deps: read/write dependencies not zero, expected 0");
    end
  endtask

  task automatic test_single_accept;
    bit ok;
    req_programID[0*64 +: 64] = 64'd1;
    req_write_deps[0*DW + 2*64 +: 64] = 64'd5;
    grant_q.push_back(0);
    expect_resp(0, 2'b00, 64'd0);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (transaction_valid !== 1'b1 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL t1_latency: tv=%b ready=%b, expected tv=1 ready=0001", transaction_valid, req_ready);
    end
    req_valid = '0;
    checks++;
    if (owner_programID !== 64'd1 || write_dependencies[2*64 +: 64] !== 64'd5) begin
      errors++;
      $display("FAIL t1_data: owner=%0d wslot2=%0d, expected owner=1 wslot2=5",
               owner_programID, write_dependencies[2*64 +: 64]);
    end
    repeat (3) @(negedge clk);
    transaction_accepted = 1'b1;
    exp_accept++;
    @(negedge clk);
    transaction_accepted = 1'b0;
    checks++;
    if (resp_done !== 4'b0001) begin
      errors++;
      $display("FAIL t1_done: got %b, expected 0001", resp_done);
    end
    @(negedge clk);
    checks++;
    if (accept_count !== 32'(exp_accept) || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_count: acc=%0d busy=%b, expected acc=%0d busy=0", accept_count, busy, exp_accept);
    end
  endtask

  task automatic test_conflict_exhaust;
    bit ok;
    int prev;
    prev = 0;
    req_programID[1*64 +: 64] = 64'd2;
    req_read_deps[1*DW + 10*64 +: 64] = 64'd5;
    grant_q.push_back(1);
    expect_resp(1, 2'b01, 64'd1);
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      wait_tv(20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL t2_issue%0d: no transaction_valid within 20 cycles, expected pulse", k);
      end
      if (k == 0) req_valid = '0;
      if (k > 0) begin
        checks++;
        if (cyc - prev !== 10) begin
          errors++;
          $display("FAIL t2_spacing%0d: got %0d cycles, expected 10", k, cyc - prev);
        end
      end
      prev = cyc;
      checks++;
      if (owner_programID !== 64'd2 || read_dependencies[10*64 +: 64] !== 64'd5) begin
        errors++;
        $display("FAIL t2_data%0d: owner=%0d rslot10=%0d, expected 2 and 5", k, owner_programID,
                 read_dependencies[10*64 +: 64]);
      end
      @(negedge clk);
      has_conflict = 1'b1;
      conflicting_id = 64'd1;
      exp_conflict++;
      @(negedge clk);
      has_conflict = 1'b0;
      conflicting_id = '0;
    end
    checks++;
    if (resp_done !== 4'b0010) begin
      errors++;
      $display("FAIL t2_done: got %b, expected 0010", resp_done);
    end
    @(negedge clk);
    checks++;
    if (conflict_count !== 32'(exp_conflict)) begin
      errors++;
      $display("FAIL t2_count: conf=%0d, expected %0d", conflict_count, exp_conflict);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int t0;
    req_programID[2*64 +: 64] = 64'd3;
    grant_q.push_back(2);
    expect_resp(2, 2'b10, 64'd0);
    req_valid = 4'b0100;
    wait_tv(20, ok);
    t0 = cyc;
    req_valid = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t4_issue: no transaction_valid within 20 cycles, expected pulse");
    end
    wait_done(300, ok);
    checks++;
    if (!ok || cyc - t0 !== 257) begin
      errors++;
      $display("FAIL t4_timeout: done_seen=%b after %0d cycles, expected done after 257", ok, cyc - t0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_retry_accept;
    bit ok;
    int t0;
    req_programID[3*64 +: 64] = 64'd9;
    grant_q.push_back(3);
    expect_resp(3, 2'b00, 64'd7);
    req_valid = 4'b1000;
    wait_tv(20, ok);
    t0 = cyc;
    req_valid = '0;
    @(negedge clk);
    has_conflict = 1'b1;
    conflicting_id = 64'd7;
    exp_conflict++;
    @(negedge clk);
    has_conflict = 1'b0;
    conflicting_id = '0;
    wait_tv(20, ok);
    checks++;
    if (!ok || cyc - t0 !== 10 || req_ready !== 4'b0000 || owner_programID !== 64'd9) begin
      errors++;
      $display("FAIL t5_reissue: seen=%b spacing=%0d ready=%b owner=%0d, expected 1 10 0000 9",
               ok, cyc - t0, req_ready, owner_programID);
    end
    @(negedge clk);
    transaction_accepted = 1'b1;
    has_conflict = 1'b1;
    conflicting_id = 64'd8;
    exp_accept++;
    @(negedge clk);
    transaction_accepted = 1'b0;
    has_conflict = 1'b0;
    conflicting_id = '0;
    checks++;
    if (resp_done !== 4'b1000) begin
      errors++;
      $display("FAIL t5_done: got %b, expected 1000", resp_done);
    end
    @(negedge clk);
    checks++;
    if (accept_count !== 32'(exp_accept) || conflict_count !== 32'(exp_conflict)) begin
      errors++;
      $display("FAIL t5_count: acc=%0d conf=%0d, expected %0d %0d", accept_count, conflict_count,
               exp_accept, exp_conflict);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int prev;
    int order[5];
    logic [63:0] ids[5];
    order = '{0, 1, 2, 3, 0};
    ids   = '{64'd16, 64'd17, 64'd18, 64'd19, 64'd32};
    prev = 0;
    for (int i = 0; i < 4; i++) req_programID[i*64 +: 64] = ids[i];
    for (int k = 0; k < 5; k++) begin
      grant_q.push_back(order[k]);
      expect_resp(order[k], 2'b00, 64'd0);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_tv(20, ok);
      checks++;
      if (!ok || owner_programID !== ids[k]) begin
        errors++;
        $display("FAIL t3_grant%0d: seen=%b owner=%0d, expected owner=%0d", k, ok, owner_programID, ids[k]);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev !== 4) begin
          errors++;
          $display("FAIL t3_spacing%0d: got %0d cycles, expected 4", k, cyc - prev);
        end
      end
      prev = cyc;
      if (k == 0) req_programID[0*64 +: 64] = ids[4];
      else req_valid[order[k]] = 1'b0;
      @(negedge clk);
      transaction_accepted = 1'b1;
      exp_accept++;
      @(negedge clk);
      transaction_accepted = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || accept_count !== 32'(exp_accept)) begin
      errors++;
      $display("FAIL t3_end: busy=%b acc=%0d, expected busy=0 acc=%0d", busy, accept_count, exp_accept);
    end
  endtask

  task automatic test_reset_in_backoff;
    bit ok;
    req_programID[1*64 +: 64] = 64'd40;
    req_programID[3*64 +: 64] = 64'd43;
    grant_q.push_back(1);
    req_valid = 4'b0010;
    wait_tv(20, ok);
    req_valid = '0;
    @(negedge clk);
    has_conflict = 1'b1;
    conflicting_id = 64'd3;
    @(negedge clk);
    has_conflict = 1'b0;
    conflicting_id = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_accept = 0;
    exp_conflict = 0;
    checks++;
    if ({req_ready, resp_done, resp_status, resp_conflict_id, owner_programID, transaction_valid,
         busy, accept_count, conflict_count} !== '0 || read_dependencies !== '0 || write_dependencies !== '0) begin
      errors++;
      $display("FAIL t6_reset_outputs: done=%b st=%b owner=%0d tv=%b busy=%b acc=%0d conf=%0d, expected all 0",
               resp_done, resp_status, owner_programID, transaction_valid, busy, accept_count, conflict_count);
    end
    grant_q.push_back(1);
    expect_resp(1, 2'b00, 64'd0);
    req_valid = 4'b1010;
    wait_tv(20, ok);
    checks++;
    if (!ok || owner_programID !== 64'd40) begin
      errors++;
      $display("FAIL t6_ptr: seen=%b owner=%0d, expected owner=40", ok, owner_programID);
    end
    req_valid = '0;
    @(negedge clk);
    transaction_accepted = 1'b1;
    exp_accept++;
    @(negedge clk);
    transaction_accepted = 1'b0;
    checks++;
    if (resp_done !== 4'b0010) begin
      errors++;
      $display("FAIL t6_done: got %b, expected 0010", resp_done);
    end
    @(negedge clk);
    checks++;
    if (accept_count !== 32'(exp_accept) || conflict_count !== 32'(exp_conflict)) begin
      errors++;
      $display("FAIL t6_count: acc=%0d conf=%0d, expected %0d %0d", accept_count, conflict_count,
               exp_accept, exp_conflict);
    end
  endtask

  initial begin
    test_reset();
    test_single_accept();
    test_conflict_exhaust();
    test_timeout();
    test_retry_accept();
    test_back_to_back();
    test_reset_in_backoff();
    repeat (2) @(negedge clk);
    checks++;
    if (grant_q.size() != 0 || exp_idx_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d grants and %0d responses outstanding, expected 0 and 0",
               grant_q.size(), exp_idx_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
